// File: rtl/sd_read_sequencer_if.sv
// sd_read_sequencer_if: SD-controller handshake bus plus the valid/ready byte sink.
// master is the sequencer side; slave is the SD controller and byte consumer.
interface sd_read_sequencer_if;
  logic        sd_rd;
  logic [31:0] sd_addr;
  logic [7:0]  sd_data;
  logic        sd_busy;
  logic        sd_hs_host;
  logic        sd_hs_ctrl;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  modport master (
    output sd_rd, sd_addr, sd_hs_host, tx_data, tx_valid,
    input  sd_data, sd_busy, sd_hs_ctrl, tx_ready
  );
  modport slave (
    input  sd_rd, sd_addr, sd_hs_host, tx_data, tx_valid,
    output sd_data, sd_busy, sd_hs_ctrl, tx_ready
  );
endinterface

// File: rtl/sd_read_sequencer.sv
// sd_read_sequencer: reads num_blocks SD blocks byte-by-byte and streams them to a valid/ready sink.
// Define SDSEQ_TIMEOUT_EN to add per-wait timeouts that park the FSM in FAIL with a sticky err.
module sd_read_sequencer #(
  parameter int          BLOCK_BYTES = 512,
  parameter logic [23:0] TIMEOUT_CYC = 24'd10_000_000
) (
  input  logic                      CLK,
  input  logic                      RESET,
  input  logic                      start,
  input  logic [31:0]               start_addr,
  input  logic [15:0]               num_blocks,
  sd_read_sequencer_if.master       bus,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic [15:0]               blk_cnt
);
  typedef enum logic [3:0] {
    IDLE, WAIT_RDY, ISSUE, WAIT_ACC, WAIT_BYTE, ACK, ACK_LOW, BLK_END, FINISH, FAIL
  } state_e;
  localparam logic [10:0] BB = 11'(BLOCK_BYTES);
  state_e      state_q, state_d, nxt;
  logic        sync_q;
  logic [31:0] addr_q, addr_d;
  logic [15:0] rem_q, rem_d, blk_q, blk_d;
  logic [9:0]  byte_q, byte_d;
  logic [10:0] byte_inc;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d, done_q, done_d;
  logic        full, capture;
  // The holding register counts as empty when its byte leaves on this same edge.
  always_comb begin
    nxt      = state_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    blk_d    = blk_q;
    byte_d   = byte_q;
    done_d   = 1'b0;
    byte_inc = {1'b0, byte_q} + 11'd1;
    full     = valid_q && !bus.tx_ready;
    capture  = state_q == WAIT_BYTE && bus.sd_hs_ctrl && !full;
    valid_d  = capture || full;
    data_d   = capture ? bus.sd_data : data_q;
    case (state_q)
      IDLE: if (start && sync_q) begin
        if (num_blocks == 16'd0) done_d = 1'b1;
        else begin
          addr_d = start_addr;
          rem_d  = num_blocks;
          blk_d  = 16'd0;
          nxt    = WAIT_RDY;
        end
      end
      WAIT_RDY:  nxt = bus.sd_busy ? WAIT_RDY : ISSUE;
      ISSUE:     nxt = bus.sd_busy ? WAIT_ACC : ISSUE;
      WAIT_ACC:  nxt = WAIT_BYTE;
      WAIT_BYTE: nxt = capture ? ACK : WAIT_BYTE;
      ACK:       nxt = bus.sd_hs_ctrl ? ACK : ACK_LOW;
      ACK_LOW: begin
        byte_d = byte_inc == BB ? 10'd0 : byte_inc[9:0];
        nxt    = byte_inc == BB ? BLK_END : WAIT_BYTE;
      end
      BLK_END: if (!bus.sd_busy) begin
        blk_d  = blk_q + 16'd1;
        addr_d = addr_q + 32'd1;
        rem_d  = rem_q - 16'd1;
        nxt    = rem_q == 16'd1 ? FINISH : WAIT_RDY;
      end
      FINISH: if (!valid_q) begin
        done_d = 1'b1;
        nxt    = IDLE;
      end
      FAIL:    nxt = FAIL;
      default: nxt = IDLE;
    endcase
  end
`ifdef SDSEQ_TIMEOUT_EN
  logic [23:0] tmo_q, tmo_d;
  logic        err_q, err_d, timed, hit;
  // A wait stalled only by the byte sink is not an SD fault, so it does not count.
  always_comb begin
    timed   = state_q inside {WAIT_RDY, ISSUE, WAIT_BYTE, ACK, BLK_END} && nxt == state_q
              && !(state_q == WAIT_BYTE && full);
    hit     = timed && tmo_q + 24'd1 >= TIMEOUT_CYC;
    tmo_d   = nxt != state_q ? 24'd0 : tmo_q + {23'd0, timed};
    err_d   = err_q || hit;
    state_d = hit ? FAIL : nxt;
  end
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      tmo_q <= 24'd0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  assign err = err_q;
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYC;
  assign state_d    = nxt;
  assign err        = 1'b0;
`endif
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      state_q <= IDLE;
      sync_q  <= 1'b0;
      addr_q  <= 32'd0;
      rem_q   <= 16'd0;
      blk_q   <= 16'd0;
      byte_q  <= 10'd0;
      data_q  <= 8'd0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= 1'b1;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      blk_q   <= blk_d;
      byte_q  <= byte_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  assign bus.sd_rd      = state_q == ISSUE;
  assign bus.sd_hs_host = state_q == ACK;
  assign bus.sd_addr    = state_q == FAIL ? 32'd0 : addr_q;
  assign bus.tx_data    = data_q;
  assign bus.tx_valid   = valid_q;
  assign busy           = !(state_q inside {IDLE, FAIL});
  assign done           = done_q;
  assign blk_cnt        = blk_q;
endmodule
